// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-port round-robin arbiter/sequencer in front of a stalling
//            data memory system, with read-data return and stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int STALL_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  output logic              err_timeout,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [15:0] c_stall_limit = 16'(STALL_LIMIT);

  state_t            r_state, w_state;
  logic              r_rr_last, w_rr_last;
  logic              r_gnt, w_gnt;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [DATA_W-1:0] r_p0_rdata, w_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata, w_p1_rdata;
  logic              r_p0_ack, w_p0_ack;
  logic              r_p1_ack, w_p1_ack;
  logic              r_mem_read, w_mem_read;
  logic              r_mem_write, w_mem_write;
  logic [15:0]       r_wd_cnt;
  logic [15:0]       w_wd_inc;
  logic              r_err;
  logic              w_sel;

  always_comb begin
    w_state     = r_state;
    w_rr_last   = r_rr_last;
    w_gnt       = r_gnt;
    w_we        = r_we;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_p0_rdata  = r_p0_rdata;
    w_p1_rdata  = r_p1_rdata;
    w_p0_ack    = 1'b0;
    w_p1_ack    = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_sel       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          // On a tie the port that did not win last time gets the grant
          w_sel       = (p0_req && p1_req) ? ~r_rr_last : p1_req;
          w_gnt       = w_sel;
          w_we        = w_sel ? p1_we    : p0_we;
          w_addr      = w_sel ? p1_addr  : p0_addr;
          w_wdata     = w_sel ? p1_wdata : p0_wdata;
          w_mem_read  = ~w_we;
          w_mem_write = w_we;
          w_state     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_stall) begin
          w_mem_read  = r_mem_read;
          w_mem_write = r_mem_write;
        end else begin
          w_state   = S_RESP;
          w_rr_last = r_gnt;
          if (r_gnt) w_p1_ack = 1'b1;
          else       w_p0_ack = 1'b1;
          if (!r_we) begin
            if (r_gnt) w_p1_rdata = mem_rdata;
            else       w_p0_rdata = mem_rdata;
          end
        end
      end
      S_RESP:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  assign w_wd_inc = (r_wd_cnt == 16'hFFFF) ? r_wd_cnt : r_wd_cnt + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rr_last   <= 1'b1;
      r_gnt       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_p0_ack    <= 1'b0;
      r_p1_ack    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_wd_cnt    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_rr_last   <= w_rr_last;
      r_gnt       <= w_gnt;
      r_we        <= w_we;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_p0_rdata  <= w_p0_rdata;
      r_p1_rdata  <= w_p1_rdata;
      r_p0_ack    <= w_p0_ack;
      r_p1_ack    <= w_p1_ack;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
      // Flag is raised on the same edge the counter reaches the limit
      if (r_state == S_IDLE && w_state == S_ISSUE) begin
        r_wd_cnt <= '0;
      end else if (r_state == S_ISSUE && mem_stall) begin
        r_wd_cnt <= w_wd_inc;
        if (w_wd_inc >= c_stall_limit) r_err <= 1'b1;
      end
    end
  end

  assign p0_ack      = r_p0_ack;
  assign p1_ack      = r_p1_ack;
  assign p0_rdata    = r_p0_rdata;
  assign p1_rdata    = r_p1_rdata;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign err_timeout = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer in front of the data memory system (cache plus backing memory, 10-bit word address, 32-bit data, `stall` handshake). It accepts single-word read/write requests from two independent ports, grants them round-robin, drives the memory system's `MemRead`/`MemWrite`/`addr`/`data_in`, holds the access while the memory system stalls, and returns read data with a one-cycle acknowledge. A stall watchdog flags accesses that never complete.

## Interface
- `ADDR_W`, 10: word address width
- `DATA_W`, 32: data width
- `STALL_LIMIT`, 255: stall cycles in one access before `err_timeout` sets (1..65535)

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `p0_req`  in  1  port 0 request; held high with stable fields until `p0_ack`
- `p0_we`  in  1  port 0: 1 = write, 0 = read
- `p0_addr`  in  ADDR_W  port 0 word address
- `p0_wdata`  in  DATA_W  port 0 write data
- `p0_ack`  out  1  port 0 one-cycle completion pulse
- `p0_rdata`  out  DATA_W  port 0 read data, valid when `p0_ack`=1
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_ack`, `p1_rdata`: same as port 0, for port 1
- `mem_read`  out  1  to memory system `MemRead`
- `mem_write`  out  1  to memory system `MemWrite`
- `mem_addr`  out  ADDR_W  to memory system `addr`
- `mem_wdata`  out  DATA_W  to memory system `data_in`
- `mem_rdata`  in  DATA_W  from memory system `data_out`
- `mem_stall`  in  1  from memory system `stall`
- `err_timeout`  out  1  sticky watchdog flag
- `busy`  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, RESP. Held in a register; `rr_last` (1 bit) records last granted port.
- IDLE: if exactly one `pN_req` high -> latch that port's `we`/`addr`/`wdata`, record grant, go ISSUE. If both high -> grant port `~rr_last`. Neither -> stay.
- ISSUE: `mem_read` = ~latched_we, `mem_write` = latched_we; `mem_addr`/`mem_wdata` = latched fields. An access completes on the rising edge where ISSUE and `mem_stall`=0; that edge captures `mem_rdata` (reads only) into the granted port's `rdata` register, updates `rr_last`, goes RESP. `mem_stall`=1 -> stay in ISSUE, all `mem_*` outputs unchanged.
- RESP: granted port's `ack`=1 for exactly this cycle; `mem_read`=`mem_write`=0; next state IDLE unconditionally (requester drops `req` this cycle).
- `pN_rdata` holds its value until the next completed read on that port; writes leave it unchanged.
- Watchdog: 16-bit counter clears on entry to ISSUE, increments each ISSUE cycle with `mem_stall`=1, saturates; reaching `STALL_LIMIT` sets `err_timeout`. Access is not aborted. `err_timeout` clears only on reset.
- `mem_read` and `mem_write` are never both 1; both 0 outside ISSUE.
- Fields of a port are ignored when its `req`=0; `req` dropped before `ack` is a protocol violation, behaviour unspecified.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, `rr_last`=1 (port 0 wins first tie), all outputs 0 including `pN_rdata`, `mem_addr`, `mem_wdata`, `err_timeout`, counter. Reset mid-access drops `mem_read`/`mem_write` immediately; transaction abandoned, no `ack`; requester re-requests.
- All outputs registered (`busy` decoded from state register).
- No-stall latency: `req` sampled at edge 0 -> ISSUE cycle 1 -> `ack`/`rdata` valid cycle 2. Each stall cycle adds one.
- Back-to-back: one access per 3 cycles minimum; IDLE cycle after RESP is mandatory.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1...
- Watchdog: with `STALL_LIMIT`=N, `err_timeout` high from the cycle after the Nth consecutive stall cycle.

## Test plan
- Reset then single read: `p0_req`=1, `p0_we`=0, `p0_addr`=0x000, `mem_stall`=0, `mem_rdata`=0x12345678 -> `mem_read`=1 for one cycle at addr 0x000, `p0_ack` pulse 2 cycles after request with `p0_rdata`=0x12345678; `p1_ack` stays 0.
- Write with 3-cycle stall: `p1_req`=1, `p1_we`=1, `p1_addr`=0x3FF, `p1_wdata`=0xDEADBEEF, `mem_stall` high 3 cycles -> `mem_write`=1, `mem_addr`=0x3FF, `mem_wdata`=0xDEADBEEF stable 4 cycles, `p1_ack` 5 cycles after request, `p1_rdata` unchanged.
- Simultaneous requests after reset, both held: port 0 acked first, then port 1, then port 0; never both `mem_read` and `mem_write`; each grant 3 cycles apart.
- Watchdog with `STALL_LIMIT`=4: `mem_stall` held 6 cycles on a read -> `err_timeout` rises after 4th stall cycle, access still completes with `ack`, flag stays 1 until reset.
- Reset asserted during ISSUE with `mem_stall`=1 -> `mem_read`, `busy`, `ack` all 0 immediately; after release, re-issued request completes normally with port 0 priority.
- Read-after-write to 0x000 (write 0xDEADBEEF, memory model returns it) -> read `p0_rdata`=0xDEADBEEF.
